// File: rtl/memory_game_pkg.sv
// Shared types and constants for the sequence-memory game engine.
// State codes stay plain 3-bit constants so game_state can be decoded by legacy consumers.
package memory_game_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE      = 3'd0;
   localparam state_t SHOW_ON   = 3'd1;
   localparam state_t SHOW_GAP  = 3'd2;
   localparam state_t INPUT     = 3'd3;
   localparam state_t GAME_OVER = 3'd4;

   typedef enum logic [1:0] {
      DIFF_EASY = 2'd0,
      DIFF_MED  = 2'd1,
      DIFF_HARD = 2'd2
   } diff_t;

   localparam logic [3:0] KEY_A      = 4'd10;
   localparam logic [3:0] KEY_B      = 4'd11;
   localparam logic [3:0] KEY_C      = 4'd12;
   localparam logic [3:0] KEY_SUBMIT = 4'd13;
   localparam logic [3:0] KEY_CLEAR  = 4'd14;
   localparam logic [3:0] KEY_ABORT  = 4'd15;

endpackage

// File: rtl/memory_game_core_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with the symbol folded into 0..NUM_SYMBOLS-1.
// sym is combinational from the current LFSR state; the register reloads SEED while rst is high.
module game_lfsr
   import memory_game_pkg::*;
#(
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int          SYM_BITS    = 4,
   parameter int          NUM_SYMBOLS = 10
)(
   input  logic                clk,
   input  logic                rst,
   output logic [SYM_BITS-1:0] sym
);

   localparam logic [SYM_BITS:0] NSYM = (SYM_BITS + 1)'(NUM_SYMBOLS);

   logic [15:0]         lfsr;
   logic                fb;
   logic [SYM_BITS-1:0] raw;

   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], fb};
      end
   end

   // Alphabet is more than half the raw range, so a single subtraction always lands in range.
   assign raw = lfsr[SYM_BITS-1:0];
   assign sym = ({1'b0, raw} >= NSYM) ? (raw - NSYM[SYM_BITS-1:0]) : raw;

endmodule

// File: rtl/memory_game_core.sv
// Sequence-memory game engine: shows a growing LFSR symbol sequence, then checks keyed replies.
// All outputs are registers that change on the same edge as the state; key events are never stalled.
module memory_game_core
   import memory_game_pkg::*;
#(
   parameter int          MAX_LEN        = 16,
   parameter int          SYM_BITS       = 4,
   parameter int          NUM_SYMBOLS    = 10,
   parameter int          ON_EASY        = 50000000,
   parameter int          ON_MED         = 30000000,
   parameter int          ON_HARD        = 15000000,
   parameter int          GAP_CYCLES     = 5000000,
   parameter int          TIMEOUT_CYCLES = 250000000,
   parameter int          LIVES          = 3,
   parameter logic [15:0] SEED           = 16'hACE1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic [13:0]                  disp_value,
   output logic                         disp_blank,
   output logic [2:0]                   game_state,
   output logic [13:0]                  score,
   output logic [13:0]                  high_score,
   output logic [$clog2(LIVES+1)-1:0]   lives_left,
   output logic                         win
);

   localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LENW = $clog2(MAX_LEN + 1);
   localparam int LVW  = $clog2(LIVES + 1);

   localparam logic [LENW-1:0] MAX_LEN_L = LENW'(MAX_LEN);
   localparam logic [LENW-1:0] LEN_ONE   = LENW'(1);
   localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
   localparam logic [LVW-1:0]  LIVES_L   = LVW'(LIVES);
   localparam logic [LVW-1:0]  LV_ONE    = LVW'(1);
   localparam logic [31:0]     GAP_LOAD  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0]     TO_LOAD   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]      NSYM_KEY  = 5'(NUM_SYMBOLS);

   state_t              state;
   diff_t               diff;
   logic [31:0]         cnt;
   logic [IDXW-1:0]     idx;
   logic [LENW-1:0]     len;
   logic                buf_vld;
   logic [SYM_BITS-1:0] buf_val;
   logic [SYM_BITS-1:0] seq [MAX_LEN];
   logic [SYM_BITS-1:0] sym;

   logic                is_abort, is_start, is_digit, is_clear, is_submit;
   diff_t               key_diff;
   logic [SYM_BITS-1:0] seq_cur, seq_nxt, seq_first;
   logic                idx_last, timed_out, sub_ok, sub_bad;
   logic                lose_life, round_done, game_won;
   logic [13:0]         score_inc;
   logic [LVW-1:0]      lives_dec;
   logic                seq_we;
   logic [IDXW-1:0]     seq_wa;

   game_lfsr #(
      .SEED        (SEED),
      .SYM_BITS    (SYM_BITS),
      .NUM_SYMBOLS (NUM_SYMBOLS)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .sym (sym)
   );

   function automatic logic [31:0] on_cycles(input diff_t d);
      case (d)
         DIFF_EASY: return 32'(ON_EASY - 1);
         DIFF_MED:  return 32'(ON_MED - 1);
         default:   return 32'(ON_HARD - 1);
      endcase
   endfunction

   function automatic logic [13:0] max14(input logic [13:0] a, input logic [13:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      is_abort  = key_valid && (key_code == KEY_ABORT);
      is_start  = key_valid && ((key_code == KEY_A) || (key_code == KEY_B) || (key_code == KEY_C));
      is_digit  = key_valid && (key_code <= 4'd9) && ({1'b0, key_code} < NSYM_KEY);
      is_clear  = key_valid && (key_code == KEY_CLEAR);
      is_submit = key_valid && (key_code == KEY_SUBMIT);

      key_diff = DIFF_HARD;
      if (key_code == KEY_A) begin
         key_diff = DIFF_EASY;
      end else if (key_code == KEY_B) begin
         key_diff = DIFF_MED;
      end

      seq_cur   = seq[idx];
      seq_nxt   = seq[idx + IDX_ONE];
      seq_first = seq[0];
      idx_last  = (LENW'(idx) == (len - LEN_ONE));
      score_inc = score + 14'd1;
      lives_dec = lives_left - LV_ONE;

      // A key in the expiry cycle wins over the timeout, hence the !key_valid term.
      timed_out  = (state == INPUT) && !key_valid && (TIMEOUT_CYCLES != 0) && (cnt == '0);
      sub_ok     = is_submit && buf_vld && (buf_val == seq_cur);
      sub_bad    = is_submit && buf_vld && (buf_val != seq_cur);
      lose_life  = (state == INPUT) && (sub_bad || timed_out);
      round_done = (state == INPUT) && sub_ok && idx_last;
      game_won   = round_done && (len == MAX_LEN_L);

      seq_we = ((state == IDLE) || (state == GAME_OVER)) && is_start;
      seq_wa = '0;
      if (round_done && !game_won) begin
         seq_we = 1'b1;
         seq_wa = len[IDXW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (seq_we) begin
         seq[seq_wa] <= sym;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         diff       <= DIFF_EASY;
         cnt        <= '0;
         idx        <= '0;
         len        <= '0;
         buf_vld    <= 1'b0;
         buf_val    <= '0;
         disp_value <= '0;
         disp_blank <= 1'b0;
         score      <= '0;
         high_score <= '0;
         lives_left <= LIVES_L;
         win        <= 1'b0;
      end else if (is_abort && (state != IDLE)) begin
         state      <= IDLE;
         cnt        <= '0;
         buf_vld    <= 1'b0;
         disp_value <= '0;
         disp_blank <= 1'b0;
      end else begin
         case (state)
            IDLE, GAME_OVER: begin
               if (is_start) begin
                  state      <= SHOW_ON;
                  diff       <= key_diff;
                  cnt        <= on_cycles(key_diff);
                  idx        <= '0;
                  len        <= LEN_ONE;
                  buf_vld    <= 1'b0;
                  score      <= '0;
                  lives_left <= LIVES_L;
                  win        <= 1'b0;
                  disp_value <= 14'(sym);
                  disp_blank <= 1'b0;
               end
            end

            SHOW_ON, SHOW_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 32'd1;
               end else if ((state == SHOW_ON) && (GAP_CYCLES != 0)) begin
                  state      <= SHOW_GAP;
                  cnt        <= GAP_LOAD;
                  disp_blank <= 1'b1;
               end else if (!idx_last) begin
                  state      <= SHOW_ON;
                  idx        <= idx + IDX_ONE;
                  cnt        <= on_cycles(diff);
                  disp_value <= 14'(seq_nxt);
                  disp_blank <= 1'b0;
               end else begin
                  state      <= INPUT;
                  idx        <= '0;
                  buf_vld    <= 1'b0;
                  cnt        <= TO_LOAD;
                  disp_blank <= 1'b1;
               end
            end

            INPUT: begin
               if (lose_life) begin
                  lives_left <= lives_dec;
                  idx        <= '0;
                  buf_vld    <= 1'b0;
                  disp_blank <= 1'b0;
                  if (lives_dec == '0) begin
                     state      <= GAME_OVER;
                     disp_value <= score;
                     high_score <= max14(high_score, score);
                  end else begin
                     state      <= SHOW_ON;
                     cnt        <= on_cycles(diff);
                     disp_value <= 14'(seq_first);
                  end
               end else if (round_done) begin
                  score      <= score_inc;
                  idx        <= '0;
                  buf_vld    <= 1'b0;
                  disp_blank <= 1'b0;
                  if (game_won) begin
                     state      <= GAME_OVER;
                     win        <= 1'b1;
                     disp_value <= score_inc;
                     high_score <= max14(high_score, score_inc);
                  end else begin
                     state      <= SHOW_ON;
                     len        <= len + LEN_ONE;
                     cnt        <= on_cycles(diff);
                     disp_value <= 14'(seq_first);
                  end
               end else if (key_valid) begin
                  cnt <= TO_LOAD;
                  if (is_digit) begin
                     buf_vld    <= 1'b1;
                     buf_val    <= SYM_BITS'(key_code);
                     disp_value <= 14'(key_code);
                     disp_blank <= 1'b0;
                  end else if (is_clear) begin
                     buf_vld    <= 1'b0;
                     disp_blank <= 1'b1;
                  end else if (sub_ok) begin
                     idx     <= idx + IDX_ONE;
                     buf_vld <= 1'b0;
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt <= cnt - 32'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign game_state = state;

endmodule
